// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared states and constants for the SD block reader
package sd_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_FINISH
    } state_t;

    localparam logic [7:0]  TOKEN_START = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;
endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - byte-wide CRC16-CCITT (init 0, no reflection) with clear and enable
module sd_crc16 import sd_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d, nxt;

    always_comb begin
        nxt = crc_q;
        for (int i = 7; i >= 0; i--) begin
            if (nxt[15] ^ din[i]) nxt = {nxt[14:0], 1'b0} ^ CRC16_POLY;
            else                  nxt = {nxt[14:0], 1'b0};
        end
        crc_d = crc_q;
        if (clr)     crc_d = '0;
        else if (en) crc_d = nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - SPI-mode SD single block reader: token wait, payload stream, CRC check
module sd_block_reader import sd_pkg::*; #(
    parameter int CLK_DIV       = 96,
    parameter int BLOCK_LEN     = 512,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       done,
    output logic       crc_err,
    output logic       tok_err
);
    localparam int HALF    = CLK_DIV / 2;
    localparam int DIV_W   = $clog2(HALF + 1);
    localparam int CNT_MAX = (BLOCK_LEN > TOKEN_TIMEOUT) ? BLOCK_LEN : TOKEN_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d, crc_hi_q, crc_hi_d, data_q, data_d;
    logic             sclk_q, sclk_d, pend_q, pend_d, fin_q, fin_d;
    logic             data_valid_q, data_valid_d, done_q, done_d;
    logic             crc_err_q, crc_err_d, tok_err_q, tok_err_d;

    logic        tick, stall, run, rise, fall, byte_done, handshake, deliver;
    logic        crc_clr, crc_en;
    logic [7:0]  byte_in, deliver_byte;
    logic [15:0] crc_val;

    sd_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (deliver_byte),
        .crc (crc_val)
    );

    // A held byte or an undrained output parks sclk low; a high sclk may always fall.
    assign tick      = (div_q == DIV_W'(HALF - 1));
    assign stall     = !sclk_q && (pend_q || (state_q == ST_FINISH && data_valid_q));
    assign run       = (state_q != ST_IDLE) && !stall;
    assign rise      = run && tick && !sclk_q;
    assign fall      = run && tick && sclk_q;
    assign byte_in   = {shift_q[6:0], miso};
    assign byte_done = rise && (bit_q == 3'd7);
    assign handshake = data_valid_q && data_ready;

    always_comb begin
        state_d      = state_q;
        div_d        = run ? (tick ? '0 : div_q + DIV_W'(1)) : '0;
        sclk_d       = (run && tick) ? !sclk_q : sclk_q;
        bit_d        = rise ? bit_q + 3'd1 : bit_q;
        shift_d      = rise ? byte_in : shift_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        fin_d        = fin_q;
        crc_hi_d     = crc_hi_q;
        data_d       = data_q;
        data_valid_d = data_valid_q && !data_ready;
        done_d       = 1'b0;
        crc_err_d    = crc_err_q;
        tok_err_d    = tok_err_q;
        crc_clr      = 1'b0;
        deliver      = 1'b0;
        deliver_byte = byte_in;

        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d   = ST_WAIT_TOKEN;
                    crc_err_d = 1'b0;
                    tok_err_d = 1'b0;
                    cnt_d     = '0;
                    bit_d     = '0;
                    pend_d    = 1'b0;
                    fin_d     = 1'b0;
                    crc_clr   = 1'b1;
                end
            end
            ST_WAIT_TOKEN: begin
                if (byte_done) begin
                    if (byte_in == TOKEN_START) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else if (byte_in == IDLE_BYTE && cnt_q != CNT_W'(TOKEN_TIMEOUT - 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        tok_err_d = 1'b1;
                        state_d   = ST_FINISH;
                    end
                end
            end
            ST_DATA: begin
                if (byte_done) begin
                    if (data_valid_q && !data_ready) pend_d = 1'b1;
                    else                             deliver = 1'b1;
                end else if (pend_q && handshake) begin
                    deliver      = 1'b1;
                    deliver_byte = shift_q;
                    pend_d       = 1'b0;
                end
                if (deliver) begin
                    data_d       = deliver_byte;
                    data_valid_d = 1'b1;
                    if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                        state_d = ST_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (byte_done) begin
                    if (cnt_q == '0) begin
                        crc_hi_d = byte_in;
                        cnt_d    = CNT_W'(1);
                    end else begin
                        crc_err_d = ({crc_hi_q, byte_in} != crc_val);
                        state_d   = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (byte_done) fin_d = 1'b1;
                if (fin_q && fall) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        crc_en = deliver;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            crc_hi_q     <= '0;
            data_q       <= '0;
            sclk_q       <= 1'b0;
            pend_q       <= 1'b0;
            fin_q        <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
            tok_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            crc_hi_q     <= crc_hi_d;
            data_q       <= data_d;
            sclk_q       <= sclk_d;
            pend_q       <= pend_d;
            fin_q        <= fin_d;
            data_valid_q <= data_valid_d;
            done_q       <= done_d;
            crc_err_q    <= crc_err_d;
            tok_err_q    <= tok_err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign cs_n       = (state_q == ST_IDLE);
    assign sclk       = sclk_q;
    assign mosi       = 1'b1;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign done       = done_q;
    assign crc_err    = crc_err_q;
    assign tok_err    = tok_err_q;
endmodule

// File: tb/tb_sd_block_reader.sv
// tb/tb_sd_block_reader.sv - self-checking bench with SPI card model and stream consumer
module tb_sd_block_reader;
    localparam int CLK_DIV       = 4;
    localparam int BLOCK_LEN     = 512;
    localparam int TOKEN_TIMEOUT = 16;
    localparam int BUDGET        = 40000;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b1, data_ready = 1'b0;
    logic       busy, sclk, cs_n, mosi, data_valid, done, crc_err, tok_err;
    logic [7:0] data;

    int errors = 0;
    int checks = 0;

    logic [7:0] card_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int   bi = 7;
    logic sclk_prev = 1'b0;
    int   rise_cnt = 0;
    bit   dv_seen = 1'b0;
    int   stab_viol = 0;
    logic [7:0] last_data = 8'h00;
    bit   last_stall = 1'b0;
    int   stall_at = -1, stall_len = 0, hold = 0, rand_pct = 0;

    sd_block_reader #(
        .CLK_DIV       (CLK_DIV),
        .BLOCK_LEN     (BLOCK_LEN),
        .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .done       (done),
        .crc_err    (crc_err),
        .tok_err    (tok_err)
    );

    always #5 clk = ~clk;

    // Card: shifts the head byte MSB first, moving to the next bit after each sclk rise.
    always @(negedge clk) begin : card
        logic [7:0] cur;
        if (cs_n) begin
            bi = 7;
        end else if (sclk && !sclk_prev) begin
            rise_cnt++;
            if (bi == 0) begin
                bi = 7;
                if (card_q.size() > 0) void'(card_q.pop_front());
            end else begin
                bi--;
            end
        end
        sclk_prev = sclk;
        cur  = (card_q.size() > 0) ? card_q[0] : 8'hFF;
        miso = cur[bi];
    end

    always @(negedge clk) begin : consumer
        logic rdy;
        if (last_stall && (!data_valid || data !== last_data)) stab_viol++;
        if (hold > 0) begin
            rdy = 1'b0;
            hold--;
        end else if (stall_at >= 0 && rx_q.size() == stall_at && data_valid) begin
            rdy      = 1'b0;
            hold     = stall_len - 1;
            stall_at = -1;
        end else begin
            rdy = (rand_pct == 0) || (int'($urandom_range(0, 99)) >= rand_pct);
        end
        data_ready = rdy;
        if (data_valid) dv_seen = 1'b1;
        if (data_valid && rdy) rx_q.push_back(data);
        last_stall = data_valid && !rdy;
        last_data  = data;
    end

    // Remainder of the message followed by 16 zero bits, divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc16_model(input logic [7:0] msg[$]);
        logic [16:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < msg.size() + 2; k++) begin
            b = (k < msg.size()) ? msg[k] : 8'h00;
            for (int i = 7; i >= 0; i--) begin
                r = {r[15:0], b[i]};
                if (r[16]) r = r ^ 17'h11021;
            end
        end
        return r[15:0];
    endfunction

    function automatic int first_mismatch();
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            if (rx_q[k] !== exp_q[k]) return k;
        return -1;
    endfunction

    task automatic make_block(input bit rnd, input bit flip);
        logic [15:0] c;
        exp_q.delete();
        card_q.delete();
        for (int i = 0; i < BLOCK_LEN; i++)
            exp_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
        c = crc16_model(exp_q);
        if (flip) c[0] = ~c[0];
        card_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
        foreach (exp_q[k]) card_q.push_back(exp_q[k]);
        card_q.push_back(c[15:8]);
        card_q.push_back(c[7:0]);
    endtask

    task automatic prep();
        rx_q.delete();
        rise_cnt  = 0;
        dv_seen   = 1'b0;
        stab_viol = 0;
    endtask

    task automatic run_xfer(input bit start_on_done, output bit timed_out, output bit busy_ok,
                            output bit done_again, output bit busy_after);
        int n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_ok = (busy === 1'b1) && (cs_n === 1'b0);
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= BUDGET);
        if (start_on_done) start = 1'b1;
        @(negedge clk); start = 1'b0;
        done_again = (done === 1'b1);
        busy_after = (busy === 1'b1) || (cs_n !== 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got=%b exp=1", cs_n); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi got=%b exp=1", mosi); end
        checks++; if (data !== 8'h00 || data_valid !== 1'b0) begin errors++; $display("FAIL rst_data got=%h/%b exp=00/0", data, data_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%b/%b exp=0/0", busy, done); end
        checks++; if (crc_err !== 1'b0 || tok_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b/%b exp=0/0", crc_err, tok_err); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_block();
        bit to, bo, da, ba;
        int mm;
        make_block(1'b0, 1'b0);
        prep();
        run_xfer(1'b1, to, bo, da, ba);
        checks++; if (!bo) begin errors++; $display("FAIL gb_busy_start got=0 exp=1"); end
        checks++; if (to) begin errors++; $display("FAIL gb_done_timeout got=timeout exp=done"); end
        checks++; if (rx_q.size() != BLOCK_LEN) begin errors++; $display("FAIL gb_len got=%0d exp=%0d", rx_q.size(), BLOCK_LEN); end
        mm = first_mismatch();
        checks++; if (mm >= 0) begin errors++; $display("FAIL gb_data idx=%0d got=%h exp=%h", mm, rx_q[mm], exp_q[mm]); end
        checks++; if (crc_err !== 1'b0 || tok_err !== 1'b0) begin errors++; $display("FAIL gb_status got=%b/%b exp=0/0", crc_err, tok_err); end
        checks++; if (da) begin errors++; $display("FAIL gb_done_width got=2+ cycles exp=1"); end
        checks++; if (ba) begin errors++; $display("FAIL gb_start_on_done got=accepted exp=ignored"); end
    endtask

    task automatic test_bad_crc();
        bit to, bo, da, ba;
        int mm;
        make_block(1'b1, 1'b1);
        prep();
        run_xfer(1'b0, to, bo, da, ba);
        checks++; if (to) begin errors++; $display("FAIL bc_done_timeout got=timeout exp=done"); end
        checks++; if (rx_q.size() != BLOCK_LEN) begin errors++; $display("FAIL bc_len got=%0d exp=%0d", rx_q.size(), BLOCK_LEN); end
        mm = first_mismatch();
        checks++; if (mm >= 0) begin errors++; $display("FAIL bc_data idx=%0d got=%h exp=%h", mm, rx_q[mm], exp_q[mm]); end
        checks++; if (crc_err !== 1'b1 || tok_err !== 1'b0) begin errors++; $display("FAIL bc_status got=%b/%b exp=1/0", crc_err, tok_err); end
    endtask

    task automatic test_timeout();
        bit to, bo, da, ba;
        card_q.delete();
        prep();
        run_xfer(1'b0, to, bo, da, ba);
        checks++; if (to) begin errors++; $display("FAIL to_done_timeout got=timeout exp=done"); end
        checks++; if (tok_err !== 1'b1 || crc_err !== 1'b0) begin errors++; $display("FAIL to_status got=%b/%b exp=1/0", tok_err, crc_err); end
        checks++; if (rise_cnt != (TOKEN_TIMEOUT + 1) * 8) begin errors++; $display("FAIL to_rises got=%0d exp=%0d", rise_cnt, (TOKEN_TIMEOUT + 1) * 8); end
        checks++; if (dv_seen) begin errors++; $display("FAIL to_no_data got=data_valid exp=none"); end
    endtask

    task automatic test_bad_token();
        bit to, bo, da, ba;
        card_q = '{8'hFF, 8'h05};
        prep();
        run_xfer(1'b0, to, bo, da, ba);
        checks++; if (to) begin errors++; $display("FAIL bt_done_timeout got=timeout exp=done"); end
        checks++; if (tok_err !== 1'b1) begin errors++; $display("FAIL bt_tok_err got=%b exp=1", tok_err); end
        checks++; if (rx_q.size() != 0 || dv_seen) begin errors++; $display("FAIL bt_payload got=%0d exp=0", rx_q.size()); end
        checks++; if (rise_cnt != 24) begin errors++; $display("FAIL bt_rises got=%0d exp=24", rise_cnt); end
    endtask

    task automatic test_backpressure();
        bit to, bo, da, ba;
        int n, r0, r1, mm;
        logic s0, b1;
        make_block(1'b1, 1'b0);
        prep();
        stall_at  = 10;
        stall_len = 1000;
        n = 0; r0 = 0; r1 = 0; s0 = 1'b1; b1 = 1'b0;
        fork
            run_xfer(1'b0, to, bo, da, ba);
            begin
                while (hold == 0 && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                repeat (200) @(negedge clk);
                r0 = rise_cnt;
                s0 = sclk;
                start = 1'b1;
                @(negedge clk); start = 1'b0;
                repeat (500) @(negedge clk);
                r1 = rise_cnt;
                b1 = busy;
            end
        join
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL bp_stall_seen got=never exp=stall"); end
        checks++; if (s0 !== 1'b0 || r1 != r0) begin errors++; $display("FAIL bp_sclk_hold got=sclk%b rises+%0d exp=sclk0 rises+0", s0, r1 - r0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL bp_busy_stall got=%b exp=1", b1); end
        checks++; if (to) begin errors++; $display("FAIL bp_done_timeout got=timeout exp=done"); end
        checks++; if (rx_q.size() != BLOCK_LEN) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", rx_q.size(), BLOCK_LEN); end
        mm = first_mismatch();
        checks++; if (mm >= 0) begin errors++; $display("FAIL bp_data idx=%0d got=%h exp=%h", mm, rx_q[mm], exp_q[mm]); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
        checks++; if (crc_err !== 1'b0 || tok_err !== 1'b0) begin errors++; $display("FAIL bp_status got=%b/%b exp=0/0", crc_err, tok_err); end
    endtask

    task automatic test_reset_midblock();
        bit to, bo, da, ba;
        int n, mm;
        make_block(1'b1, 1'b0);
        prep();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (rx_q.size() < 200 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL rm_reach got=%0d exp=200", rx_q.size()); end
        rst = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got=cs%b sclk%b busy%b exp=1/0/0", cs_n, sclk, busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rm_dv got=%b exp=0", data_valid); end
        @(negedge clk);
        rst = 1'b0;
        make_block(1'b1, 1'b0);
        prep();
        rand_pct = 25;
        run_xfer(1'b0, to, bo, da, ba);
        rand_pct = 0;
        checks++; if (to) begin errors++; $display("FAIL rm_done_timeout got=timeout exp=done"); end
        checks++; if (rx_q.size() != BLOCK_LEN) begin errors++; $display("FAIL rm_len got=%0d exp=%0d", rx_q.size(), BLOCK_LEN); end
        mm = first_mismatch();
        checks++; if (mm >= 0) begin errors++; $display("FAIL rm_data idx=%0d got=%h exp=%h", mm, rx_q[mm], exp_q[mm]); end
        checks++; if (crc_err !== 1'b0 || tok_err !== 1'b0) begin errors++; $display("FAIL rm_status got=%b/%b exp=0/0", crc_err, tok_err); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL rm_stable got=%0d exp=0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_good_block();
        test_bad_crc();
        test_timeout();
        test_bad_token();
        test_backpressure();
        test_reset_midblock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
